// File: rtl/delay_meas_pkg.sv
// Shared definitions for the loop-delay measurement scheduler.
// FSM encoding and datapath widths used by the top and its timer.
package delay_meas_pkg;

  localparam int DELAY_W = 16;
  localparam int TOCNT_W = 8;
  localparam int TIMER_W = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_MEAS   = 3'd2,
    S_SETTLE = 3'd3,
    S_ACCUM  = 3'd4,
    S_GAP    = 3'd5
  } state_t;

endpackage

// File: rtl/meas_timer.sv
// Loadable down-counter with zero flag, shared by the MEAS, SETTLE and GAP phases.
// Holds at zero until reloaded.
module meas_timer
  import delay_meas_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               zero
);

  logic [TIMER_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/loop_delay_meas_scheduler.sv
// Periodic ring loop-delay measurement sequencer with sample averaging and lost-loop count.
// Optional macro LOOP_DELAY_MINMAX_EN adds MinLoopDelay/MaxLoopDelay tracking outputs.
module loop_delay_meas_scheduler
  import delay_meas_pkg::*;
#(
  parameter int LOG2_SAMPLES   = 3,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int GAP_CYCLES     = 10000,
  parameter int SETTLE_CYCLES  = 4
) (
  input  logic               Clk_100MHz,
  input  logic               rst_n,
  input  logic               Enable,
  input  logic               SocGrant,
  input  logic               LoopReturn,
  input  logic [DELAY_W-1:0] RegLoopDelay,
  output logic               SocReq,
  output logic               StartCounting,
  output logic [DELAY_W-1:0] AveLoopDelay,
  output logic               AveValid,
  output logic [TOCNT_W-1:0] TimeoutCnt,
  output logic               Busy
`ifdef LOOP_DELAY_MINMAX_EN
  ,
  output logic [DELAY_W-1:0] MinLoopDelay,
  output logic [DELAY_W-1:0] MaxLoopDelay
`endif
);

  localparam int ACC_W = DELAY_W + LOG2_SAMPLES;

  state_t               state, next_state;
  logic                 timer_load;
  logic [TIMER_W-1:0]   timer_val;
  logic                 timer_zero;
  logic                 timeout_evt;
  logic                 going_idle;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     acc_sum;
  logic [LOG2_SAMPLES-1:0] cnt;

  meas_timer u_timer (
    .clk      (Clk_100MHz),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  always_ff @(posedge Clk_100MHz or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Each timed phase reloads the shared timer on the edge that enters it.
  always_comb begin
    next_state = state;
    timer_load = 1'b0;
    timer_val  = '0;
    case (state)
      S_IDLE: if (Enable) next_state = S_REQ;
      S_REQ: begin
        if (SocGrant) begin
          next_state = S_MEAS;
          timer_load = 1'b1;
          timer_val  = TIMER_W'(TIMEOUT_CYCLES - 1);
        end
      end
      S_MEAS: begin
        if (LoopReturn) begin
          next_state = S_SETTLE;
          timer_load = 1'b1;
          timer_val  = TIMER_W'(SETTLE_CYCLES - 1);
        end else if (timer_zero) begin
          next_state = S_GAP;
          timer_load = 1'b1;
          timer_val  = TIMER_W'(GAP_CYCLES - 1);
        end
      end
      S_SETTLE: if (timer_zero) next_state = S_ACCUM;
      S_ACCUM: begin
        next_state = S_GAP;
        timer_load = 1'b1;
        timer_val  = TIMER_W'(GAP_CYCLES - 1);
      end
      S_GAP: if (timer_zero) next_state = Enable ? S_REQ : S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  assign SocReq        = (state == S_REQ);
  assign StartCounting = (state == S_MEAS) || (state == S_SETTLE) || (state == S_ACCUM);
  assign Busy          = (state != S_IDLE);

  assign timeout_evt = (state == S_MEAS) && !LoopReturn && timer_zero;
  assign going_idle  = (state == S_GAP) && timer_zero && !Enable;
  assign acc_sum     = acc + ACC_W'(RegLoopDelay);

  always_ff @(posedge Clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      acc          <= '0;
      cnt          <= '0;
      AveLoopDelay <= '0;
      AveValid     <= 1'b0;
      TimeoutCnt   <= '0;
    end else begin
      AveValid <= 1'b0;
      if (state == S_ACCUM) begin
        cnt <= cnt + 1'b1;
        if (cnt == '1) begin
          AveLoopDelay <= acc_sum[ACC_W-1:LOG2_SAMPLES];
          AveValid     <= 1'b1;
          acc          <= '0;
        end else begin
          acc <= acc_sum;
        end
      end
      // A partial average never survives a stop/restart.
      if (going_idle) begin
        acc <= '0;
        cnt <= '0;
      end
      if (timeout_evt && (TimeoutCnt != '1)) TimeoutCnt <= TimeoutCnt + 1'b1;
    end
  end

`ifdef LOOP_DELAY_MINMAX_EN
  always_ff @(posedge Clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      MinLoopDelay <= '1;
      MaxLoopDelay <= '0;
    end else if ((state == S_IDLE) && Enable) begin
      MinLoopDelay <= '1;
      MaxLoopDelay <= '0;
    end else if (state == S_ACCUM) begin
      if (RegLoopDelay < MinLoopDelay) MinLoopDelay <= RegLoopDelay;
      if (RegLoopDelay > MaxLoopDelay) MaxLoopDelay <= RegLoopDelay;
    end
  end
`endif

endmodule

// File: tb/tb_loop_delay_meas_scheduler.sv
// Self-checking bench for loop_delay_meas_scheduler: directed table, hand sequences,
// and randomized measurements checked against a sample-queue reference model.
module tb_loop_delay_meas_scheduler;

  localparam int L2    = 3;
  localparam int NS    = 1 << L2;
  localparam int TO    = 50;
  localparam int GAP   = 20;
  localparam int SET   = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        Enable;
  logic        SocGrant;
  logic        LoopReturn;
  logic [15:0] RegLoopDelay;
  logic        SocReq;
  logic        StartCounting;
  logic [15:0] AveLoopDelay;
  logic        AveValid;
  logic [7:0]  TimeoutCnt;
  logic        Busy;

  int tests = 0;
  int fails = 0;

  // Reference model state: pending good samples, last average, lost-loop count.
  int          m_q[$];
  logic [15:0] m_ave = '0;
  int          m_to  = 0;

  loop_delay_meas_scheduler #(
    .LOG2_SAMPLES   (L2),
    .TIMEOUT_CYCLES (TO),
    .GAP_CYCLES     (GAP),
    .SETTLE_CYCLES  (SET)
  ) dut (
    .Clk_100MHz    (clk),
    .rst_n         (rst_n),
    .Enable        (Enable),
    .SocGrant      (SocGrant),
    .LoopReturn    (LoopReturn),
    .RegLoopDelay  (RegLoopDelay),
    .SocReq        (SocReq),
    .StartCounting (StartCounting),
    .AveLoopDelay  (AveLoopDelay),
    .AveValid      (AveValid),
    .TimeoutCnt    (TimeoutCnt),
    .Busy          (Busy)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one measurement outcome. ret==0 means the loop never returns.
  task automatic model_meas(input int ret, input int val, output logic valid);
    valid = 1'b0;
    if (ret == 0) begin
      m_to = (m_to >= 255) ? 255 : m_to + 1;
    end else begin
      m_q.push_back(val);
      if (m_q.size() == NS) begin
        int sum = 0;
        foreach (m_q[k]) sum += m_q[k];
        m_ave = 16'(sum / NS);
        m_q.delete();
        valid = 1'b1;
      end
    end
  endtask

  // Plays TX and RX partner for one measurement cycle and checks the outcome.
  task automatic do_meas(input int gdly, input int ret, input logic [15:0] val, input logic drop_en,
                         input logic exp_valid, input logic [15:0] exp_ave, input int exp_to);
    int n = 0;
    while (!SocReq && n < 200) begin
      tick();
      n++;
    end
    if (!SocReq) begin
      chk("socreq_wait_timeout", 0, 1);
      return;
    end
    repeat (gdly) tick();
    chk("socreq_held", SocReq, 1);
    SocGrant = 1'b1;
    tick();
    SocGrant = 1'b0;
    chk("meas_entry", {SocReq, StartCounting, Busy}, 3'b011);
    if (drop_en) Enable = 1'b0;
    if (ret == 0) begin
      repeat (TO - 1) tick();
      chk("meas_last_cycle_counting", StartCounting, 1);
      tick();
      chk("timeout_startcounting", StartCounting, 0);
    end else begin
      repeat (ret - 1) tick();
      LoopReturn   = 1'b1;
      RegLoopDelay = val;
      tick();
      LoopReturn = 1'b0;
      repeat (SET) tick();
      chk("accum_counting", StartCounting, 1);
      tick();
      chk("gap_startcounting", StartCounting, 0);
    end
    chk("ave_valid", AveValid, exp_valid);
    chk("ave_value", AveLoopDelay, exp_ave);
    chk("timeout_cnt", TimeoutCnt, exp_to);
    // Spurious grant/return during GAP must be ignored; AveValid is one cycle only.
    LoopReturn = 1'b1;
    SocGrant   = 1'b1;
    tick();
    LoopReturn = 1'b0;
    SocGrant   = 1'b0;
    chk("gap_ignore", {SocReq, StartCounting, AveValid, Busy}, 4'b0001);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (Busy && n < GAP + 10) begin
      tick();
      n++;
    end
    chk("idle_busy", Busy, 0);
    chk("idle_socreq", SocReq, 0);
  endtask

  typedef struct {
    int          gdly;
    int          ret;
    logic [15:0] val;
    logic        exp_valid;
    logic [15:0] exp_ave;
    int          exp_to;
  } vec_t;

  vec_t tbl[18];

  initial begin
    logic v;
    for (int i = 0; i < 8; i++) begin
      tbl[i].gdly      = 2;
      tbl[i].ret       = 30;
      tbl[i].val       = 16'd300;
      tbl[i].exp_valid = (i == 7);
      tbl[i].exp_ave   = (i == 7) ? 16'd300 : 16'd0;
      tbl[i].exp_to    = 0;
    end
    for (int i = 0; i < 8; i++) begin
      tbl[8+i].gdly      = i % 4;
      tbl[8+i].ret       = 5 + 5 * i;
      tbl[8+i].val       = 16'(100 * (i + 1));
      tbl[8+i].exp_valid = (i == 7);
      tbl[8+i].exp_ave   = (i == 7) ? 16'd450 : 16'd300;
      tbl[8+i].exp_to    = 0;
    end
    tbl[16] = '{gdly: 1, ret: 0,  val: 16'd0,    exp_valid: 1'b0, exp_ave: 16'd450, exp_to: 1};
    tbl[17] = '{gdly: 0, ret: TO, val: 16'd1000, exp_valid: 1'b0, exp_ave: 16'd450, exp_to: 1};

    rst_n = 1'b0; Enable = 1'b0; SocGrant = 1'b0; LoopReturn = 1'b0; RegLoopDelay = '0;
    repeat (3) tick();
    chk("reset_outputs", {SocReq, StartCounting, AveValid, Busy}, 4'b0000);
    chk("reset_ave", AveLoopDelay, 0);
    chk("reset_tocnt", TimeoutCnt, 0);
    rst_n = 1'b1;
    repeat (2) tick();
    chk("idle_while_disabled", Busy, 0);
    Enable = 1'b1;

    foreach (tbl[i])
      do_meas(tbl[i].gdly, tbl[i].ret, tbl[i].val, 1'b0,
              tbl[i].exp_valid, tbl[i].exp_ave, tbl[i].exp_to);

    // Three samples pending (1000,10,20), fourth taken while disabling: all discarded.
    do_meas(1, 10, 16'd10, 1'b0, 1'b0, 16'd450, 1);
    do_meas(1, 12, 16'd20, 1'b0, 1'b0, 16'd450, 1);
    do_meas(0, 14, 16'd30, 1'b1, 1'b0, 16'd450, 1);
    wait_idle();
    repeat (5) tick();
    chk("stay_idle", {Busy, AveLoopDelay}, {1'b0, 16'd450});
    Enable = 1'b1;
    for (int i = 0; i < 8; i++)
      do_meas(2, 20, 16'd64, 1'b0, (i == 7), (i == 7) ? 16'd64 : 16'd450, 1);

    // Randomized measurements against the model.
    m_q.delete();
    m_ave = 16'd64;
    m_to  = 1;
    for (int i = 0; i < 48; i++) begin
      int r   = int'($urandom_range(0, 9));
      int ret = (r == 0) ? 0 : (r == 1) ? TO : int'($urandom_range(1, TO - 1));
      int val = int'($urandom_range(0, 65535));
      model_meas(ret, val, v);
      do_meas(int'($urandom_range(0, 3)), ret, 16'(val), 1'b0, v, m_ave, m_to);
    end

    // Force enough lost loops to saturate the counter.
    for (int i = 0; i < 300; i++) begin
      model_meas(0, 0, v);
      do_meas(int'($urandom_range(0, 2)), 0, 16'd0, 1'b0, 1'b0, m_ave, m_to);
    end
    chk("tocnt_saturated", TimeoutCnt, 255);

    // Asynchronous reset in the middle of a measurement.
    while (!SocReq) tick();
    SocGrant = 1'b1;
    tick();
    SocGrant = 1'b0;
    repeat (5) tick();
    chk("pre_reset_counting", StartCounting, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_drop", {SocReq, StartCounting, Busy}, 3'b000);
    tick();
    chk("reset_ave_mid", AveLoopDelay, 0);
    chk("reset_tocnt_mid", TimeoutCnt, 0);
    chk("reset_valid_mid", AveValid, 0);
    Enable = 1'b0;
    rst_n  = 1'b1;
    repeat (2) tick();
    chk("idle_after_reset", Busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
